// File: rtl/lfsr_pkg.sv
// Shared XNOR-LFSR tap table and successor function for the generator and checker.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_chk_state_e;

  function automatic logic [31:0] lfsr_tap_bit(input int unsigned tap);
    return 32'd1 << (tap - 1);
  endfunction

  // Tap mask for widths 3..32; tap t maps to word bit t-1.
  function automatic logic [31:0] lfsr_taps(input int unsigned num_bits);
    case (num_bits)
      3:  return lfsr_tap_bit(3)  | lfsr_tap_bit(2);
      4:  return lfsr_tap_bit(4)  | lfsr_tap_bit(3);
      5:  return lfsr_tap_bit(5)  | lfsr_tap_bit(3);
      6:  return lfsr_tap_bit(6)  | lfsr_tap_bit(5);
      7:  return lfsr_tap_bit(7)  | lfsr_tap_bit(6);
      8:  return lfsr_tap_bit(8)  | lfsr_tap_bit(6)  | lfsr_tap_bit(5) | lfsr_tap_bit(4);
      9:  return lfsr_tap_bit(9)  | lfsr_tap_bit(5);
      10: return lfsr_tap_bit(10) | lfsr_tap_bit(7);
      11: return lfsr_tap_bit(11) | lfsr_tap_bit(9);
      12: return lfsr_tap_bit(12) | lfsr_tap_bit(6)  | lfsr_tap_bit(4) | lfsr_tap_bit(1);
      13: return lfsr_tap_bit(13) | lfsr_tap_bit(4)  | lfsr_tap_bit(3) | lfsr_tap_bit(1);
      14: return lfsr_tap_bit(14) | lfsr_tap_bit(5)  | lfsr_tap_bit(3) | lfsr_tap_bit(1);
      15: return lfsr_tap_bit(15) | lfsr_tap_bit(14);
      16: return lfsr_tap_bit(16) | lfsr_tap_bit(15) | lfsr_tap_bit(13) | lfsr_tap_bit(4);
      17: return lfsr_tap_bit(17) | lfsr_tap_bit(14);
      18: return lfsr_tap_bit(18) | lfsr_tap_bit(11);
      19: return lfsr_tap_bit(19) | lfsr_tap_bit(6)  | lfsr_tap_bit(2) | lfsr_tap_bit(1);
      20: return lfsr_tap_bit(20) | lfsr_tap_bit(17);
      21: return lfsr_tap_bit(21) | lfsr_tap_bit(19);
      22: return lfsr_tap_bit(22) | lfsr_tap_bit(21);
      23: return lfsr_tap_bit(23) | lfsr_tap_bit(18);
      24: return lfsr_tap_bit(24) | lfsr_tap_bit(23) | lfsr_tap_bit(22) | lfsr_tap_bit(17);
      25: return lfsr_tap_bit(25) | lfsr_tap_bit(22);
      26: return lfsr_tap_bit(26) | lfsr_tap_bit(6)  | lfsr_tap_bit(2) | lfsr_tap_bit(1);
      27: return lfsr_tap_bit(27) | lfsr_tap_bit(5)  | lfsr_tap_bit(2) | lfsr_tap_bit(1);
      28: return lfsr_tap_bit(28) | lfsr_tap_bit(25);
      29: return lfsr_tap_bit(29) | lfsr_tap_bit(27);
      30: return lfsr_tap_bit(30) | lfsr_tap_bit(6)  | lfsr_tap_bit(4) | lfsr_tap_bit(1);
      31: return lfsr_tap_bit(31) | lfsr_tap_bit(28);
      32: return lfsr_tap_bit(32) | lfsr_tap_bit(22) | lfsr_tap_bit(2) | lfsr_tap_bit(1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic lfsr_fb(input int unsigned num_bits, input logic [31:0] word);
    return ~^(word & lfsr_taps(num_bits));
  endfunction

  // Shift left, feedback into the LSB, upper unused bits cleared.
  function automatic logic [31:0] lfsr_next(input int unsigned num_bits, input logic [31:0] word);
    logic [31:0] mask;
    mask = (num_bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << num_bits) - 32'd1);
    return ((word << 1) | 32'(lfsr_fb(num_bits, word))) & mask;
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: seeds from the stream, verifies successors, locks,
// then flywheels its own prediction and counts mismatches.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_BITS   = 8,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_ERR = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [NUM_BITS-1:0] i_LFSR_Data,
  input  logic                i_Clr_Cnt,
  output logic                o_Lock,
  output logic                o_Err,
  output logic [ERR_W-1:0]    o_Err_Cnt
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_ERR + 1);

  lfsr_chk_state_e     r_state;
  logic [NUM_BITS-1:0] r_pred;
  logic [GOOD_W-1:0]   r_good_cnt;
  logic [BAD_W-1:0]    r_bad_cnt;
  logic                r_lock;
  logic                r_err;
  logic [ERR_W-1:0]    r_err_cnt;

  logic                w_match;
  logic                w_all_ones;
  logic                w_lock_miss;
  logic [NUM_BITS-1:0] w_next_in;
  logic [NUM_BITS-1:0] w_next_pred;
  logic [GOOD_W-1:0]   w_good_inc;
  logic [BAD_W-1:0]    w_bad_inc;

  assign w_match     = (i_LFSR_Data == r_pred);
  assign w_all_ones  = &i_LFSR_Data;
  assign w_lock_miss = enable && (r_state == LOCKED) && !w_match;
  assign w_next_in   = NUM_BITS'(lfsr_next(NUM_BITS, 32'(i_LFSR_Data)));
  assign w_next_pred = NUM_BITS'(lfsr_next(NUM_BITS, 32'(r_pred)));
  assign w_good_inc  = r_good_cnt + GOOD_W'(1);
  assign w_bad_inc   = r_bad_cnt + BAD_W'(1);

  // Lock FSM with prediction and match/mismatch counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SEARCH;
      r_pred     <= '0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_lock     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (enable) begin
        case (r_state)
          SEARCH: begin
            if (!w_all_ones) begin
              r_pred     <= w_next_in;
              r_good_cnt <= '0;
              r_state    <= VERIFY;
            end
          end
          VERIFY: begin
            if (w_match) begin
              r_pred     <= w_next_in;
              r_good_cnt <= w_good_inc;
              if (w_good_inc == GOOD_W'(LOCK_CNT)) begin
                r_state   <= LOCKED;
                r_bad_cnt <= '0;
                r_lock    <= 1'b1;
              end
            end else if (w_all_ones) begin
              r_good_cnt <= '0;
              r_state    <= SEARCH;
            end else begin
              r_pred     <= w_next_in;
              r_good_cnt <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: the input never reseeds the prediction here.
            r_pred <= w_next_pred;
            if (w_match) begin
              r_bad_cnt <= '0;
            end else begin
              r_err     <= 1'b1;
              r_bad_cnt <= w_bad_inc;
              if (w_bad_inc == BAD_W'(UNLOCK_ERR)) begin
                r_state <= SEARCH;
                r_lock  <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= SEARCH;
            r_lock  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating error counter; clear takes priority over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (i_Clr_Cnt) begin
      r_err_cnt <= '0;
    end else if (w_lock_miss && (r_err_cnt != {ERR_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign o_Lock    = r_lock;
  assign o_Err     = r_err;
  assign o_Err_Cnt = r_err_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker at NUM_BITS=4, LOCK_CNT=4, UNLOCK_ERR=4, ERR_W=4.
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       clr;
  logic [3:0] din;
  logic       lock;
  logic       err;
  logic [3:0] cnt;

  int checks   = 0;
  int failures = 0;
  int pos      = 0;

  // Hand-derived 4-bit XNOR sequence (taps 4,3), period 15.
  logic [3:0] seq [15] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                           4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

  always #5 clk = ~clk;

  lfsr_checker #(
    .NUM_BITS(4), .LOCK_CNT(4), .UNLOCK_ERR(4), .ERR_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .i_LFSR_Data(din), .i_Clr_Cnt(clr),
    .o_Lock(lock), .o_Err(err), .o_Err_Cnt(cnt)
  );

  task automatic step(input logic en, input logic [3:0] d, input logic c);
    @(negedge clk);
    enable = en;
    din    = d;
    clr    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_good();
    step(1'b1, seq[pos], 1'b0);
    pos = (pos + 1) % 15;
  endtask

  task automatic feed_bad(input logic c);
    step(1'b1, seq[pos] ^ 4'h1, c);
    pos = (pos + 1) % 15;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; clr = 1'b0; din = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; clr = 1'b0; din = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (lock !== 1'b0) begin failures++; $display("FAIL reset_lock got=%b want=0", lock); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (cnt !== 4'h0) begin failures++; $display("FAIL reset_cnt got=%h want=0", cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_lock();
    pos = 0;
    for (int i = 0; i < 5; i++) begin
      feed_good();
      checks++;
      if (lock !== (i == 4)) begin
        failures++; $display("FAIL clean_lock_rise word=%0d got=%b want=%b", i, lock, (i == 4));
      end
    end
    for (int i = 0; i < 45; i++) begin
      feed_good();
      checks++;
      if ({lock, err} !== 2'b10) begin
        failures++; $display("FAIL clean_hold i=%0d lock_err got=%b want=10", i, {lock, err});
      end
    end
    checks++; if (cnt !== 4'h0) begin failures++; $display("FAIL clean_cnt got=%h want=0", cnt); end
  endtask

  task automatic test_single_corruption();
    // pos is 5 here: D expected, send 5 instead
    step(1'b1, 4'h5, 1'b0);
    pos = (pos + 1) % 15;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL single_err got=%b want=1", err); end
    checks++; if (cnt !== 4'h1) begin failures++; $display("FAIL single_cnt got=%h want=1", cnt); end
    checks++; if (lock !== 1'b1) begin failures++; $display("FAIL single_lock got=%b want=1", lock); end
    for (int i = 0; i < 4; i++) begin
      feed_good();
      checks++;
      if ({lock, err, cnt} !== {2'b10, 4'h1}) begin
        failures++; $display("FAIL single_resume i=%0d got=%b%b_%h want=10_1", i, lock, err, cnt);
      end
    end
  endtask

  task automatic test_loss_of_lock();
    step(1'b1, seq[pos], 1'b1);
    pos = (pos + 1) % 15;
    checks++; if (cnt !== 4'h0) begin failures++; $display("FAIL lol_clear got=%h want=0", cnt); end
    for (int i = 0; i < 4; i++) begin
      feed_bad(1'b0);
      checks++;
      if ({lock, err, cnt} !== {(i < 3), 1'b1, 4'(i + 1)}) begin
        failures++;
        $display("FAIL lol_miss i=%0d got=%b%b_%h want=%b1_%h", i, lock, err, cnt, (i < 3), 4'(i + 1));
      end
    end
    for (int i = 0; i < 5; i++) begin
      feed_good();
      checks++;
      if ({lock, err} !== {(i == 4), 1'b0}) begin
        failures++; $display("FAIL lol_relock i=%0d got=%b%b want=%b0", i, lock, err, (i == 4));
      end
    end
  endtask

  task automatic test_lockup_word();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'hF, 1'b0);
      checks++;
      if ({lock, err} !== 2'b00) begin
        failures++; $display("FAIL lockup_hold i=%0d got=%b%b want=00", i, lock, err);
      end
    end
    pos = 3;
    for (int i = 0; i < 5; i++) begin
      feed_good();
      checks++;
      if ({lock, err} !== {(i == 4), 1'b0}) begin
        failures++; $display("FAIL lockup_relock i=%0d got=%b%b want=%b0", i, lock, err, (i == 4));
      end
    end
  endtask

  task automatic test_enable_gaps();
    logic [23:0] en_pat;
    en_pat = 24'b1011_0010_1110_0101_1001_1011;
    for (int i = 0; i < 24; i++) begin
      if (en_pat[i]) feed_good();
      else step(1'b0, seq[(pos + 5) % 15], 1'b0);
      checks++;
      if ({lock, err} !== 2'b10) begin
        failures++; $display("FAIL gaps i=%0d got=%b%b want=10", i, lock, err);
      end
    end
    checks++; if (cnt !== 4'h0) begin failures++; $display("FAIL gaps_cnt got=%h want=0", cnt); end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    for (int k = 0; k < 20; k++) begin
      feed_bad(1'b0);
      exp_cnt = (k + 1 > 15) ? 4'hF : 4'(k + 1);
      checks++;
      if ({lock, err, cnt} !== {2'b11, exp_cnt}) begin
        failures++; $display("FAIL sat k=%0d got=%b%b_%h want=11_%h", k, lock, err, cnt, exp_cnt);
      end
      if (k % 3 == 2) feed_good();
    end
    feed_bad(1'b1);
    checks++;
    if ({lock, err, cnt} !== {2'b11, 4'h0}) begin
      failures++; $display("FAIL clr_wins got=%b%b_%h want=11_0", lock, err, cnt);
    end
    feed_good();
    checks++;
    if ({lock, err, cnt} !== {2'b10, 4'h0}) begin
      failures++; $display("FAIL clr_after got=%b%b_%h want=10_0", lock, err, cnt);
    end
  endtask

  task automatic test_reset_mid_locked();
    feed_bad(1'b0);
    checks++;
    if ({lock, err, cnt} !== {2'b11, 4'h1}) begin
      failures++; $display("FAIL pre_reset got=%b%b_%h want=11_1", lock, err, cnt);
    end
    #1;
    rst_n = 1'b0; enable = 1'b0;
    #1;
    checks++;
    if ({lock, err, cnt} !== {2'b00, 4'h0}) begin
      failures++; $display("FAIL async_reset got=%b%b_%h want=00_0", lock, err, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      feed_good();
      checks++;
      if ({lock, err} !== {(i == 4), 1'b0}) begin
        failures++; $display("FAIL reset_relock i=%0d got=%b%b want=%b0", i, lock, err, (i == 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_corruption();
    test_loss_of_lock();
    test_lockup_word();
    test_enable_gaps();
    test_saturation();
    test_reset_mid_locked();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
